// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and serialises them 8N1-style.
// Optional even parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t                state, state_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_reg_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  tx_next, busy_next;
  logic                  last_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_bit, parity_bit_next;
`endif

  assign last_tick = (bit_cnt == CNT_LAST);
  assign shifted   = shift_reg >> 1;

  // Pop when ready for a new word: idle, or the final cycle of the stop bit.
  assign fifo_read = !reset && !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && last_tick));

  // Next-state and next-output logic; tx/busy are computed one cycle ahead so the line is registered.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = last_tick ? '0 : bit_cnt + 1'b1;
    bit_idx_next   = bit_idx;
    shift_reg_next = shift_reg;
    tx_next        = tx;
    busy_next      = busy;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_bit_next = parity_bit;
`endif
    if (fifo_read) begin
      state_next     = START;
      bit_cnt_next   = '0;
      bit_idx_next   = '0;
      shift_reg_next = fifo_read_data;
      tx_next        = 1'b0;
      busy_next      = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit_next = ^fifo_read_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          bit_cnt_next = '0;
          tx_next      = 1'b1;
          busy_next    = 1'b0;
        end
        START: begin
          if (last_tick) begin
            state_next = DATA;
            tx_next    = shift_reg[0];
          end else begin
            tx_next = 1'b0;
          end
        end
        DATA: begin
          if (last_tick) begin
            if (bit_idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_next = PARITY;
              tx_next    = parity_bit;
`else
              state_next = STOP;
              tx_next    = 1'b1;
`endif
            end else begin
              bit_idx_next   = bit_idx + 1'b1;
              shift_reg_next = shifted;
              tx_next        = shifted[0];
            end
          end else begin
            tx_next = shift_reg[0];
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = parity_bit;
          end
        end
`endif
        STOP: begin
          // A non-empty FIFO here was already taken by the fifo_read branch above.
          if (last_tick) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
          end else begin
            tx_next = 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          tx_next      = 1'b1;
          busy_next    = 1'b0;
        end
      endcase
    end
  end

  // State, counters, shift register and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_reg_next;
      tx        <= tx_next;
      busy      <= busy_next;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= parity_bit_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: frame-level reference model plus table-driven and directed sequences.
module tb_fifo_uart_tx;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_read;
  logic          tx;
  logic          busy;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read(fifo_read), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [9:0] frame; // {stop, data, start}, bit 0 transmitted first
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] fq[$];
  logic line[$];
  logic cap_tx[$];
  logic cap_busy[$];
  logic cap_rd[$];
  logic last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference line waveform for one word, one entry per clock cycle.
  task automatic append_frame(input logic [DW-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
`ifdef FIFO_UART_TX_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(1'b1);
    foreach (bits[b]) for (int k = 0; k < C; k++) line.push_back(bits[b]);
  endtask

  // One clock: drive inputs at negedge, compare outputs against the model, advance FIFO and model.
  task automatic cycle(input logic rst);
    logic exp_tx, exp_busy, exp_rd;
    logic [DW-1:0] w;
    @(negedge clk);
    reset = rst;
    fifo_empty = (fq.size() == 0);
    fifo_read_data = fifo_empty ? '0 : fq[0];
    w = fifo_read_data;
    #1;
    exp_tx   = (line.size() > 0) ? line[0] : 1'b1;
    exp_busy = (line.size() > 0);
    exp_rd   = !rst && !fifo_empty && (line.size() <= 1);
    chk("model_tx", tx, exp_tx);
    chk("model_busy", busy, exp_busy);
    chk("model_fifo_read", fifo_read, exp_rd);
    cap_tx.push_back(tx);
    cap_busy.push_back(busy);
    cap_rd.push_back(fifo_read);
    last_rd = fifo_read;
    if (fifo_read && !fifo_empty) void'(fq.pop_front());
    if (rst) begin
      line.delete();
    end else begin
      if (line.size() > 0) void'(line.pop_front());
      if (exp_rd) append_frame(w);
    end
  endtask

  task automatic clear_cap();
    cap_tx.delete();
    cap_busy.delete();
    cap_rd.delete();
  endtask

  function automatic logic cap_at(input int i);
    return (i >= 0 && i < cap_tx.size()) ? cap_tx[i] : 1'bx;
  endfunction

  task automatic drain();
    int n = 0;
    while ((line.size() > 0 || fq.size() > 0) && n < 1000) begin
      cycle(1'b0);
      n++;
    end
    chk("drain_bounded", (n < 1000), 1'b1);
  endtask

  task automatic check_frame(input vec_t v);
    int s = -1;
    int run = 0;
    int pops = 0;
    logic [9:0] got;
    foreach (cap_busy[i]) if (cap_busy[i] && s < 0) s = i;
    chk("frame_start_seen", (s >= 0), 1'b1);
    if (s < 0) s = 0;
    for (int k = 0; k < 9; k++) got[k] = cap_at(s + k * C + C / 2);
    got[9] = cap_at(s + (NBITS - 1) * C + C / 2);
    for (int i = s; i < cap_busy.size() && cap_busy[i]; i++) run++;
    foreach (cap_rd[i]) if (cap_rd[i]) pops++;
    chk("frame_bits", got, v.frame);
    chk("frame_len", run, FRAME);
    chk("frame_pops", pops, 1);
`ifdef FIFO_UART_TX_PARITY_EN
    chk("frame_parity", cap_at(s + 9 * C + C / 2), v.par);
`endif
  endtask

  initial begin
    vec_t vecs[$];
    int p;
    int pop_idx[$];
    int s;
    int run;
    int ones;
    int bcnt;

    vecs.push_back('{8'hA5, 1'b0, 10'h34A});
    vecs.push_back('{8'h07, 1'b1, 10'h20E});
    vecs.push_back('{8'h03, 1'b0, 10'h206});
    vecs.push_back('{8'h00, 1'b0, 10'h200});
    vecs.push_back('{8'hFF, 1'b0, 10'h3FE});
    vecs.push_back('{8'h01, 1'b1, 10'h202});
    vecs.push_back('{8'h80, 1'b1, 10'h300});

    reset = 1'b1;
    fifo_empty = 1'b1;
    fifo_read_data = '0;

    // Reset held two cycles with a word waiting.
    fq.push_back(8'h11);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fifo_read", fifo_read, 1'b0);
    end
    drain();
    cycle(1'b0);
    chk("idle_after_drain", busy, 1'b0);

    // Table of single-word frames.
    foreach (vecs[i]) begin
      clear_cap();
      fq.push_back(vecs[i].data);
      for (int k = 0; k < FRAME + 6; k++) cycle(1'b0);
      check_frame(vecs[i]);
    end

    // Back-to-back 0x00 then 0xFF.
    clear_cap();
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    for (int k = 0; k < 2 * FRAME + 6; k++) cycle(1'b0);
    foreach (cap_rd[i]) if (cap_rd[i]) pop_idx.push_back(i);
    chk("b2b_pop_count", pop_idx.size(), 2);
    if (pop_idx.size() == 2) chk("b2b_pop_spacing", pop_idx[1] - pop_idx[0], FRAME);
    s = -1;
    foreach (cap_busy[i]) if (cap_busy[i] && s < 0) s = i;
    run = 0;
    if (s >= 0) for (int i = s; i < cap_busy.size() && cap_busy[i]; i++) run++;
    chk("b2b_busy_run", run, 2 * FRAME);

    // Reset during data bit 3 of 0x5A.
    fq.push_back(8'h5A);
    p = 0;
    last_rd = 1'b0;
    while (!last_rd && p < 10) begin
      cycle(1'b0);
      p++;
    end
    chk("mid_pop_seen", last_rd, 1'b1);
    for (int k = 0; k < 16; k++) cycle(1'b0);
    cycle(1'b0);
    chk("mid_bit3", tx, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    cycle(1'b1);
    cycle(1'b0);
    chk("mid_tx_after_rst", tx, 1'b1);
    chk("mid_busy_after_rst", busy, 1'b0);
    clear_cap();
    for (int k = 0; k < 20; k++) cycle(1'b0);
    ones = 0;
    foreach (cap_tx[i]) if (cap_tx[i] === 1'b1) ones++;
    bcnt = 0;
    foreach (cap_rd[i]) if (cap_rd[i] !== 1'b0) bcnt++;
    chk("mid_no_pop", bcnt, 0);
    chk("mid_tx_idle", ones, 20);

    // Empty FIFO for 100 cycles.
    clear_cap();
    for (int k = 0; k < 100; k++) cycle(1'b0);
    ones = 0;
    bcnt = 0;
    p = 0;
    foreach (cap_tx[i]) if (cap_tx[i] === 1'b1) ones++;
    foreach (cap_busy[i]) if (cap_busy[i] !== 1'b0) bcnt++;
    foreach (cap_rd[i]) if (cap_rd[i] !== 1'b0) p++;
    chk("empty_tx_high", ones, 100);
    chk("empty_busy_low", bcnt, 0);
    chk("empty_no_pop", p, 0);

    // Randomised traffic with occasional resets against the model.
    for (int it = 0; it < 150; it++) begin
      if (fq.size() < 3 && ($urandom % 2) == 0) fq.push_back(DW'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 25)); k++)
        cycle((($urandom % 60) == 0) ? 1'b1 : 1'b0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
